// File: rtl/adder_tree_pkg.sv
// rtl/adder_tree_pkg.sv - shared widths and helpers for the 16-input signed adder tree
package adder_tree_pkg;

    localparam int N_TREE_INPUTS = 16;
    localparam int TREE_WIDTH    = 4;

    // Width of a signed sum of n terms of w bits each; cannot overflow.
    function automatic int sum_width(input int w, input int n);
        return w + $clog2(n);
    endfunction

    localparam int TREE_OUT_WIDTH = sum_width(TREE_WIDTH, N_TREE_INPUTS);

endpackage

// File: rtl/adder_tree_sum_accumulator.sv
// rtl/adder_tree_sum_accumulator.sv - accumulates N_BEATS adder-tree sums into one wide signed result
module adder_tree_sum_accumulator
    import adder_tree_pkg::*;
#(
    parameter int IN_WIDTH    = 8,
    parameter int N_BEATS     = 16,
    localparam int OUT_WIDTH  = sum_width(IN_WIDTH, N_BEATS),
    localparam int CNT_WIDTH  = $clog2(N_BEATS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  in_sum,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_sum,
    output logic [CNT_WIDTH-1:0]        beat_cnt
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(N_BEATS - 1);

    logic signed [OUT_WIDTH-1:0] acc;
    logic signed [OUT_WIDTH-1:0] ext_sum;
    logic                        is_last;
    logic                        accept;
    logic                        last_accept;

    assign ext_sum = {{(OUT_WIDTH-IN_WIDTH){in_sum[IN_WIDTH-1]}}, in_sum};
    assign is_last = (beat_cnt == LAST_CNT);

    // Only the final beat of a frame can stall, and only while an older result
    // is still waiting; it goes through in the same cycle that result drains.
    assign in_ready    = rst_n & ~clear & ~(is_last & out_valid & ~out_ready);
    assign accept      = in_valid & in_ready;
    assign last_accept = accept & is_last;

    // Beat counter and running partial sum; clear aborts the partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            beat_cnt <= '0;
        end else if (clear) begin
            acc      <= '0;
            beat_cnt <= '0;
        end else if (accept) begin
            if (is_last) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + CNT_WIDTH'(1);
                if (beat_cnt == '0) begin
                    acc <= ext_sum;
                end else begin
                    acc <= acc + ext_sum;
                end
            end
        end
    end

    // Result register: loads on the last beat, holds until consumed, and
    // reloads without a bubble when a drain and a new last beat coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else if (last_accept) begin
            out_valid <= 1'b1;
            out_sum   <= acc + ext_sum;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_tree_sum_accumulator.sv
// tb/tb_adder_tree_sum_accumulator.sv - directed self-checking bench for adder_tree_sum_accumulator
module tb_adder_tree_sum_accumulator;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_sum;
    logic              out_valid;
    logic              out_ready;
    logic signed [11:0] out_sum;
    logic [3:0]        beat_cnt;

    int checks;
    int errors;

    adder_tree_sum_accumulator #(
        .IN_WIDTH (8),
        .N_BEATS  (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One beat: present it, wait (bounded) until in_ready seen at negedge,
    // then step past the accepting edge. ok=0 if the budget ran out.
    task automatic send_beat(input logic signed [7:0] v, output bit ok);
        ok = 1'b0;
        in_valid = 1'b1;
        in_sum   = v;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_sum = '0; out_ready = 1'b1;
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 12'h000 || beat_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b out_sum=%h beat_cnt=%0d, want 0/000/0", out_valid, out_sum, beat_cnt);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ramp();
        bit ok;
        bit all_ok;
        all_ok = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_beat(8'(i), ok);
            all_ok &= ok;
            if (i == 2) begin
                checks++;
                if (beat_cnt !== 4'd3) begin
                    errors++;
                    $display("FAIL ramp_beat_cnt: got %0d want 3", beat_cnt);
                end
            end
            if (i < 15) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL ramp_early_valid: beat %0d out_valid=%b want 0", i, out_valid);
                end
            end
        end
        checks++;
        if (!all_ok || out_valid !== 1'b1 || out_sum !== 12'd120 || beat_cnt !== 4'd0) begin
            errors++;
            $display("FAIL ramp_result: ok=%b out_valid=%b out_sum=%0d beat_cnt=%0d, want 1/1/120/0", all_ok, out_valid, out_sum, beat_cnt);
        end
        idle_cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ramp_valid_one_cycle: got %b want 0", out_valid);
        end
    endtask

    task automatic test_extremes();
        bit ok;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_beat(-8'sd128, ok);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 12'h800) begin
            errors++;
            $display("FAIL min_sum: out_valid=%b out_sum=%h want 1/800", out_valid, out_sum);
        end
        for (int i = 0; i < 16; i++) send_beat(8'sd127, ok);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 12'h7F0) begin
            errors++;
            $display("FAIL max_sum: out_valid=%b out_sum=%h want 1/7f0", out_valid, out_sum);
        end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        int drops;
        int results;
        logic signed [11:0] got [3];
        drops = 0;
        results = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 48; c++) begin
            in_sum = 8'((c / 16) + 1);
            @(negedge clk);
            if (!in_ready) drops++;
            @(posedge clk);
            #1;
            if (out_valid) begin
                if (results < 3) got[results] = out_sum;
                results++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (drops !== 0) begin
            errors++;
            $display("FAIL b2b_in_ready: %0d drops want 0", drops);
        end
        checks++;
        if (results !== 3) begin
            errors++;
            $display("FAIL b2b_result_count: got %0d want 3", results);
        end else begin
            checks++;
            if (got[0] !== 12'd16 || got[1] !== 12'd32 || got[2] !== 12'd48) begin
                errors++;
                $display("FAIL b2b_values: got %0d %0d %0d want 16 32 48", got[0], got[1], got[2]);
            end
        end
        idle_cycle();
    endtask

    task automatic test_stall();
        bit ok;
        int acc_cnt;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_beat(8'sd2, ok);
        acc_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            send_beat(8'sd3, ok);
            if (ok) acc_cnt++;
        end
        checks++;
        if (acc_cnt !== 15 || beat_cnt !== 4'd15) begin
            errors++;
            $display("FAIL stall_partial: accepted=%0d beat_cnt=%0d want 15/15", acc_cnt, beat_cnt);
        end
        in_valid = 1'b1;
        in_sum   = 8'sd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 12'd32) begin
                errors++;
                $display("FAIL stall_hold: in_ready=%b out_valid=%b out_sum=%0d want 0/1/32", in_ready, out_valid, out_sum);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 12'd48 || beat_cnt !== 4'd0) begin
            errors++;
            $display("FAIL stall_no_bubble: out_valid=%b out_sum=%0d beat_cnt=%0d want 1/48/0", out_valid, out_sum, beat_cnt);
        end
        idle_cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_clear();
        bit ok;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) send_beat(8'sd5, ok);
        checks++;
        if (beat_cnt !== 4'd7) begin
            errors++;
            $display("FAIL clear_pre_cnt: got %0d want 7", beat_cnt);
        end
        clear    = 1'b1;
        in_valid = 1'b1;
        in_sum   = 8'sd5;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_in_ready: got %b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        clear = 1'b0;
        checks++;
        if (beat_cnt !== 4'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_state: beat_cnt=%0d out_valid=%b want 0/0", beat_cnt, out_valid);
        end
        for (int i = 0; i < 16; i++) send_beat(8'sd1, ok);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 12'd16) begin
            errors++;
            $display("FAIL clear_result: out_valid=%b out_sum=%0d want 1/16", out_valid, out_sum);
        end
        idle_cycle();
    endtask

    task automatic test_async_reset();
        bit ok;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_beat(8'sd1, ok);
        for (int i = 0; i < 9; i++) send_beat(8'sd7, ok);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (beat_cnt !== 4'd0 || out_valid !== 1'b0 || out_sum !== 12'h000 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: beat_cnt=%0d out_valid=%b out_sum=%0d in_ready=%b want 0/0/0/0", beat_cnt, out_valid, out_sum, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) send_beat(-8'sd1, ok);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 12'hFF0) begin
            errors++;
            $display("FAIL post_reset_frame: out_valid=%b out_sum=%0d want 1/-16", out_valid, out_sum);
        end
        idle_cycle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_ramp();
        test_extremes();
        test_back_to_back();
        test_stall();
        test_clear();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
